// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the digest serializer state type.
package sha256_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 8;
  localparam int unsigned DIGEST_W  = WORD_W * NUM_WORDS;

  localparam logic [31:0] H0_INIT = 32'h6a09e667;
  localparam logic [31:0] H1_INIT = 32'hbb67ae85;
  localparam logic [31:0] H2_INIT = 32'h3c6ef372;
  localparam logic [31:0] H3_INIT = 32'ha54ff53a;
  localparam logic [31:0] H4_INIT = 32'h510e527f;
  localparam logic [31:0] H5_INIT = 32'h9b05688c;
  localparam logic [31:0] H6_INIT = 32'h1f83d9ab;
  localparam logic [31:0] H7_INIT = 32'h5be0cd19;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/sha256_digest_serializer.sv
// Captures the final SHA-256 digest in one cycle and streams it out
// big-endian (H0 MSB first) as OUT_W-bit beats over valid/ready.
module sha256_digest_serializer #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned NUM_WORDS = 8,
  parameter int unsigned OUT_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        digest_valid,
  input  logic [WORD_W*NUM_WORDS-1:0] digest,
  output logic                        digest_ready,
  output logic [OUT_W-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic                        overrun,
  input  logic                        clear_overrun
);
  import sha256_pkg::*;

  localparam int unsigned DW      = WORD_W * NUM_WORDS;
  localparam int unsigned BEATS   = DW / OUT_W;
  localparam int unsigned CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PEN_IDX = (BEATS > 1) ? BEATS - 2 : 0;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] PEN_CNT  = CNT_W'(PEN_IDX);

  state_t            state;
  logic [DW-1:0]     shreg;
  logic [CNT_W-1:0]  cnt;

  assign digest_ready = (state == IDLE);
  assign out_data     = shreg[DW-1 -: OUT_W];

  // The shift register empties itself as beats leave, so out_data reads 0 in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // A set from a rejected digest takes priority over a clear in the same cycle.
      if (digest_valid && (state != IDLE)) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (digest_valid) begin
            shreg     <= digest;
            cnt       <= '0;
            state     <= STREAM;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_last  <= (BEATS == 1);
          end
        end
        STREAM: begin
          if (out_ready) begin
            shreg <= shreg << OUT_W;
            cnt   <= CNT_W'(cnt + 1'b1);
            if (cnt == LAST_CNT) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_last <= (cnt == PEN_CNT);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Scoreboard bench for the digest serializer: byte-wide and word-wide instances.
module tb_sha256_digest_serializer;
  import sha256_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  localparam logic [255:0] ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] ONES = {256{1'b1}};

  logic         clk = 1'b0;
  logic         reset;
  logic         dv8, rdy8, clr8, dr8, v8, l8, busy8, ovr8;
  logic [255:0] dig8;
  logic [7:0]   d8;
  logic         dv32, rdy32, clr32, dr32, v32, l32, busy32, ovr32;
  logic [255:0] dig32;
  logic [31:0]  d32;

  int   errors = 0;
  int   checks = 0;
  int   beats8 = 0;
  int   beats32 = 0;
  exp_t q8[$];
  exp_t q32[$];

  always #5 clk = ~clk;

  sha256_digest_serializer #(.WORD_W(32), .NUM_WORDS(8), .OUT_W(8)) dut8 (
    .clk(clk), .reset(reset), .digest_valid(dv8), .digest(dig8), .digest_ready(dr8),
    .out_data(d8), .out_valid(v8), .out_ready(rdy8), .out_last(l8), .busy(busy8),
    .overrun(ovr8), .clear_overrun(clr8));

  sha256_digest_serializer #(.WORD_W(32), .NUM_WORDS(8), .OUT_W(32)) dut32 (
    .clk(clk), .reset(reset), .digest_valid(dv32), .digest(dig32), .digest_ready(dr32),
    .out_data(d32), .out_valid(v32), .out_ready(rdy32), .out_last(l32), .busy(busy32),
    .overrun(ovr32), .clear_overrun(clr32));

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-wide monitor: compares each transferred beat and checks stall stability.
  logic       stall8 = 1'b0;
  logic [7:0] hd8;
  logic       hl8;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      stall8 = 1'b0;
    end else begin
      if (stall8) begin
        check("stall_valid", 256'(v8), 256'(1'b1));
        check("stall_data", 256'(d8), 256'(hd8));
        check("stall_last", 256'(l8), 256'(hl8));
      end
      if (v8 && rdy8) begin
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat8: got beat %0h expected no beat at %0t", d8, $time);
        end else begin
          e = q8.pop_front();
          check("beat8_data", 256'(d8), 256'(e.data[7:0]));
          check("beat8_last", 256'(l8), 256'(e.last));
        end
        beats8++;
      end else if (!v8) begin
        check("last8_without_valid", 256'(l8), 256'(1'b0));
      end
      stall8 = v8 && !rdy8;
      hd8    = d8;
      hl8    = l8;
    end
  end

  // Word-wide monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && v32 && rdy32) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat32: got beat %0h expected no beat at %0t", d32, $time);
      end else begin
        e = q32.pop_front();
        check("beat32_data", 256'(d32), 256'(e.data));
        check("beat32_last", 256'(l32), 256'(e.last));
      end
      beats32++;
    end
  end

  // Issue a digest to the byte-wide instance and queue its 32 expected beats.
  task automatic start8(input logic [255:0] d);
    check("pre_capture_valid", 256'(v8), 256'(1'b0));
    dig8 = d;
    dv8  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      q8.push_back('{data: 32'(d[255-8*i -: 8]), last: (i == 31)});
    end
    @(posedge clk);
    #1;
    dv8 = 1'b0;
    check("capture_latency_valid", 256'(v8), 256'(1'b1));
    check("capture_busy", 256'(busy8), 256'(1'b1));
    check("capture_ready_low", 256'(dr8), 256'(1'b0));
  endtask

  // Drive out_ready until the stream ends. mode 0: always ready, 1: random with
  // 10-cycle stalls at beats 0/15/31, 2: overrun pulse at beat 5, 3: reset at beat 12.
  task automatic run8(input int mode, output int cycles, output int nbeats);
    int  base = beats8;
    int  rel;
    int  stall_left = 0;
    bit  s0 = 0, s15 = 0, s31 = 0, ovr_done = 0, ovr_pend, done = 0;
    cycles = 0;
    for (int c = 0; c < 600; c++) begin
      rel = beats8 - base;
      if (!v8) begin
        done = 1;
        break;
      end
      if (mode == 3 && rel >= 12) begin
        #2;
        reset = 1'b1;
        #1;
        check("rst_valid", 256'(v8), 256'(1'b0));
        check("rst_busy", 256'(busy8), 256'(1'b0));
        check("rst_data", 256'(d8), 256'(8'h00));
        check("rst_ready", 256'(dr8), 256'(1'b1));
        q8.delete();
        rdy8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        done = 1;
        break;
      end
      ovr_pend = 0;
      if (mode == 2 && rel == 5 && !ovr_done) begin
        dig8 = ONES;
        dv8  = 1'b1;
        ovr_done = 1;
        ovr_pend = 1;
      end
      if (mode == 1) begin
        if (stall_left > 0) begin
          rdy8 = 1'b0;
          stall_left--;
        end else if ((rel == 0 && !s0) || (rel == 15 && !s15) || (rel == 31 && !s31)) begin
          if (rel == 0) s0 = 1;
          if (rel == 15) s15 = 1;
          if (rel == 31) s31 = 1;
          rdy8 = 1'b0;
          stall_left = 9;
        end else begin
          rdy8 = 1'($urandom_range(0, 1));
        end
      end else begin
        rdy8 = 1'b1;
      end
      @(posedge clk);
      #1;
      cycles++;
      dv8 = 1'b0;
      if (ovr_pend) check("overrun_set", 256'(ovr8), 256'(1'b1));
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL stream8_timeout: got no end of stream expected end within 600 cycles");
    end
    rdy8   = 1'b0;
    nbeats = beats8 - base;
  endtask

  initial begin
    int cyc, nb, base32;
    bit done32;
    reset = 1'b1;
    dv8 = 1'b0; rdy8 = 1'b0; clr8 = 1'b0; dig8 = '0;
    dv32 = 1'b0; rdy32 = 1'b0; clr32 = 1'b0; dig32 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 256'(v8), 256'(1'b0));
    check("reset_data", 256'(d8), 256'(8'h00));
    check("reset_last", 256'(l8), 256'(1'b0));
    check("reset_busy", 256'(busy8), 256'(1'b0));
    check("reset_overrun", 256'(ovr8), 256'(1'b0));
    check("reset_ready", 256'(dr8), 256'(1'b1));
    reset = 1'b0;

    // Idle with out_ready high: nothing moves.
    rdy8 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("idle_valid", 256'(v8), 256'(1'b0));
      check("idle_busy", 256'(busy8), 256'(1'b0));
    end
    check("idle_no_beats", 256'(beats8), 256'(0));
    rdy8 = 1'b0;

    // "abc" digest at full rate.
    start8(ABC);
    run8(0, cyc, nb);
    check("t1_cycles", 256'(cyc), 256'(32));
    check("t1_beats", 256'(nb), 256'(32));
    check("t1_ready_after", 256'(dr8), 256'(1'b1));
    check("t1_data_zero", 256'(d8), 256'(8'h00));
    check("t1_overrun", 256'(ovr8), 256'(1'b0));

    // Random backpressure with long stalls.
    start8(ABC);
    run8(1, cyc, nb);
    check("t2_beats", 256'(nb), 256'(32));
    check("t2_queue_empty", 256'(q8.size()), 256'(0));
    check("t2_ready_after", 256'(dr8), 256'(1'b1));

    // Overrun during a stream, then clear it.
    start8(ABC);
    run8(2, cyc, nb);
    check("t3_beats", 256'(nb), 256'(32));
    check("t3_queue_empty", 256'(q8.size()), 256'(0));
    check("t3_overrun_sticky", 256'(ovr8), 256'(1'b1));
    clr8 = 1'b1;
    @(posedge clk);
    #1;
    clr8 = 1'b0;
    check("t3_overrun_cleared", 256'(ovr8), 256'(1'b0));

    // Reset mid-stream, then a new digest from its first byte.
    start8(ABC);
    run8(3, cyc, nb);
    check("t4_partial_beats", 256'(nb), 256'(12));
    check("t4_ready_post_reset", 256'(dr8), 256'(1'b1));
    start8({H0_INIT, H1_INIT, H2_INIT, H3_INIT, H4_INIT, H5_INIT, H6_INIT, H7_INIT});
    run8(0, cyc, nb);
    check("t4_new_beats", 256'(nb), 256'(32));
    check("t4_queue_empty", 256'(q8.size()), 256'(0));

    // Word-wide instance.
    for (int i = 0; i < 8; i++) begin
      q32.push_back('{data: ABC[255-32*i -: 32], last: (i == 7)});
    end
    base32 = beats32;
    dig32 = ABC;
    dv32  = 1'b1;
    @(posedge clk);
    #1;
    dv32  = 1'b0;
    rdy32 = 1'b1;
    check("t5_latency_valid", 256'(v32), 256'(1'b1));
    done32 = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (!v32) begin
        done32 = 1;
        break;
      end
    end
    if (!done32) begin
      checks++;
      errors++;
      $display("FAIL stream32_timeout: got no end of stream expected end within 100 cycles");
    end
    check("t5_beats", 256'(beats32 - base32), 256'(8));
    check("t5_queue_empty", 256'(q32.size()), 256'(0));
    check("t5_ready_after", 256'(dr32), 256'(1'b1));
    rdy32 = 1'b0;

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_digest_serializer.md
Name: sha256_digest_serializer

Overview:
Reader side of the SHA-256 hash-state registers. Captures the final 256-bit digest {H0..H7} in one cycle when the compression core signals completion. Streams it out big-endian, H0 MSB first, as OUT_W-bit beats over a valid/ready interface to the host/UART path. Owns the hand-off between the compression core and the output link.

Parameters:
WORD_W, 32, width of one hash word Hn
NUM_WORDS, 8, number of hash words in the digest
OUT_W, 8, output beat width; must divide WORD_W (legal: 8, 16, 32)

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, asynchronous, active-high
digest_valid  in  1  one-cycle pulse: digest bus holds the final hash
digest  in  WORD_W*NUM_WORDS  {H0,...,H7}; H0 occupies [255:224]
digest_ready  out  1  high when a new digest can be captured
out_data  out  OUT_W  current output beat
out_valid  out  1  out_data is valid
out_ready  in  1  downstream accepts the beat
out_last  out  1  marks the final beat of a digest
busy  out  1  a digest is being streamed
overrun  out  1  sticky: a digest_valid arrived while not ready
clear_overrun  in  1  synchronous clear of overrun

Behaviour:
- Reset values: state IDLE, shift register 0, beat counter 0.
- Outputs during and after reset: out_data 0, out_valid 0, out_last 0, busy 0, overrun 0, digest_ready 1.
- digest_ready is combinational from the state: it equals (state==IDLE).
- States: IDLE and STREAM.
- IDLE, digest_valid=1: load the shift register with digest, clear the counter, go to STREAM.
- Latency: out_valid rises in the cycle after the capture edge. In STREAM, busy=1 and out_valid=1.
- out_data is the top OUT_W bits of the shift register: first beat digest[255:248] (OUT_W=8), last beat digest[7:0].
- Handshake: a beat transfers on a clock edge where out_valid and out_ready are both high.
- On a transfer: shift the register left by OUT_W, filling with zeros, and increment the counter.
- Beat count is BEATS = WORD_W*NUM_WORDS/OUT_W (32 for the defaults). Counter width is clog2(BEATS).
- out_last=1 exactly while counter==BEATS-1 and out_valid=1.
- When the last beat transfers, go to IDLE. digest_ready rises the next cycle, and the shift register is all zeros by then.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable; there is no timeout.
- out_ready while in IDLE is ignored.
- digest_valid while state != IDLE: the input is ignored, the stream in flight is unaffected, and overrun is set on the next edge.
- This includes the cycle of the last-beat transfer, because digest_ready is still 0 then. No back-to-back capture.
- overrun clears only on reset or clear_overrun=1. If clear_overrun and a new overrun event occur in the same cycle, the set wins.
- Reset mid-stream: all state is cleared asynchronously and the partial stream is abandoned. The downstream sees out_valid drop immediately.
- digest is sampled only on the capture edge. Later changes on the digest bus have no effect.

Decomposition:
- Shared package sha256_pkg holds:
  - WORD_W=32, NUM_WORDS=8, DIGEST_W=256
  - initial hash constants H0_INIT..H7_INIT (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19)
  - the state enum {IDLE, STREAM}
- No sub-module. The shift register, counter and two-state FSM form a single module.

Test Plan:
1. Reset, then set digest = SHA-256("abc") = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. Pulse digest_valid with out_ready=1. Required: out_valid rises 1 cycle after capture; 32 consecutive beats ba,78,16,bf,...,15,ad; out_last only on beat 0xad; digest_ready=1 the cycle after.
2. Same digest, out_ready toggled randomly and held low for 10 cycles at beats 0, 15 and 31. Required: out_data and out_last stable while stalled, no beat lost or duplicated, 32 beats total.
3. Pulse digest_valid with digest=all-ones at beat 5 of the "abc" stream. Required: the stream continues unchanged to 0xad, overrun=1 from the next cycle, no all-ones beats appear, and clear_overrun returns overrun to 0.
4. Assert reset asynchronously mid-beat at beat 12. Required: out_valid, busy and out_data go to 0 immediately, digest_ready=1. A new digest then streams from its first byte.
5. Configure OUT_W=32 with the "abc" digest. Required: 8 beats ba7816bf ... f20015ad, out_last on f20015ad.
6. Hold out_ready=1 in IDLE with no digest for 20 cycles. Required: out_valid stays 0, no counter change, busy=0.
